// File: rtl/tile_mem_pkg.sv
// -----------------------------------------------------------------------------
// tile_mem_pkg
// Shared definitions for the tile memory sequencer: sequencer state encoding
// and the default matrix-dimension width and tile geometry.
// -----------------------------------------------------------------------------
package tile_mem_pkg;

   localparam int unsigned DimWidthDef = 7;
   localparam int unsigned TileRowsDef = 4;
   localparam int unsigned TileColsDef = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/tile_addr_gen.sv
// -----------------------------------------------------------------------------
// tile_addr_gen
// Row-major tile origin walker plus read address generation.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   clear_i                  : restart the walk at origin (0,0)
//   advance_i                : step to the next tile origin
//   num_rows_i, num_cols_i   : matrix dimensions of the current job
//   base_addr_i              : matrix base address
//   row_o, col_o             : current tile origin
//   addr_o                   : base + row*num_cols + col, wrapped to AddrWidth
//   last_o                   : current origin is the final tile of the job
// -----------------------------------------------------------------------------
module tile_addr_gen import tile_mem_pkg::*; #(
   parameter int unsigned AddrWidth = 10,
   parameter int unsigned TileRows  = TileRowsDef,
   parameter int unsigned TileCols  = TileColsDef,
   parameter int unsigned DimWidth  = DimWidthDef
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 advance_i,
   input  logic [DimWidth-1:0]  num_rows_i,
   input  logic [DimWidth-1:0]  num_cols_i,
   input  logic [AddrWidth-1:0] base_addr_i,
   output logic [DimWidth-1:0]  row_o,
   output logic [DimWidth-1:0]  col_o,
   output logic [AddrWidth-1:0] addr_o,
   output logic                 last_o
);

   // One extra bit so origin + tile size cannot wrap before the compare.
   localparam int unsigned ExtW = DimWidth + 1;
   localparam int unsigned SumW = AddrWidth + 2 * DimWidth;

   logic [ExtW-1:0] next_col;
   logic [ExtW-1:0] next_row;
   logic            col_wrap;

   always_comb begin
      next_col = {1'b0, col_o} + ExtW'(TileCols);
      next_row = {1'b0, row_o} + ExtW'(TileRows);
      col_wrap = next_col >= {1'b0, num_cols_i};
      last_o   = col_wrap && (next_row >= {1'b0, num_rows_i});
      addr_o   = AddrWidth'(SumW'(base_addr_i)
                          + SumW'(row_o) * SumW'(num_cols_i)
                          + SumW'(col_o));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         row_o <= '0;
         col_o <= '0;
      end else if (advance_i) begin
         if (col_wrap) begin
            col_o <= '0;
            row_o <= next_row[DimWidth-1:0];
         end else begin
            col_o <= next_col[DimWidth-1:0];
         end
      end
   end

endmodule

// File: rtl/tile_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tile_mem_sequencer
// Walks a matrix in TileRows x TileCols tiles, issuing one combinational read
// per tile origin, while sharing the memory port with a loader write requester.
//   clk_i, rst_ni                 : clock, synchronous active-low reset
//   start_i                       : job start pulse (honoured only when idle)
//   num_rows_i, num_cols_i        : matrix dimensions, latched on start
//   base_addr_i                   : matrix base address, latched on start
//   busy_o, done_o                : job active; one-cycle completion pulse
//   wr_req_i, wr_addr_i, wr_gnt_o : loader write request / address / grant
//   mem_addr_o, mem_we_o          : shared memory address and write enable
//   matrix_col_o                  : latched column count
//   tile_valid_o, tile_ready_i    : tile read stream handshake
//   tile_row_o, tile_col_o        : origin of the tile being presented
// -----------------------------------------------------------------------------
module tile_mem_sequencer import tile_mem_pkg::*; #(
   parameter int unsigned AddrWidth = 10,
   parameter int unsigned TileRows  = TileRowsDef,
   parameter int unsigned TileCols  = TileColsDef,
   parameter int unsigned DimWidth  = DimWidthDef
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [DimWidth-1:0]  num_rows_i,
   input  logic [DimWidth-1:0]  num_cols_i,
   input  logic [AddrWidth-1:0] base_addr_i,
   output logic                 busy_o,
   output logic                 done_o,
   input  logic                 wr_req_i,
   input  logic [AddrWidth-1:0] wr_addr_i,
   output logic                 wr_gnt_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic                 mem_we_o,
   output logic [DimWidth-1:0]  matrix_col_o,
   output logic                 tile_valid_o,
   input  logic                 tile_ready_i,
   output logic [DimWidth-1:0]  tile_row_o,
   output logic [DimWidth-1:0]  tile_col_o
);

   state_e               state;
   state_e               next_state;
   logic [DimWidth-1:0]  rows_q;
   logic [DimWidth-1:0]  cols_q;
   logic [AddrWidth-1:0] base_q;
   logic                 prev_wr;
   logic                 start_ok;
   logic                 handshake;
   logic                 last_tile;
   logic [DimWidth-1:0]  cur_row;
   logic [DimWidth-1:0]  cur_col;
   logic [AddrWidth-1:0] rd_addr;

   assign start_ok  = (state == StIdle) && start_i;
   assign handshake = tile_valid_o && tile_ready_i;

   tile_addr_gen #(
      .AddrWidth (AddrWidth),
      .TileRows  (TileRows),
      .TileCols  (TileCols),
      .DimWidth  (DimWidth)
   ) u_addr_gen (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (start_ok),
      .advance_i   (handshake && !last_tile),
      .num_rows_i  (rows_q),
      .num_cols_i  (cols_q),
      .base_addr_i (base_q),
      .row_o       (cur_row),
      .col_o       (cur_col),
      .addr_o      (rd_addr),
      .last_o      (last_tile)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state <= StIdle;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rows_q  <= '0;
         cols_q  <= '0;
         base_q  <= '0;
         prev_wr <= 1'b0;
      end else begin
         prev_wr <= wr_gnt_o;
         if (start_ok) begin
            rows_q <= num_rows_i;
            cols_q <= num_cols_i;
            base_q <= base_addr_i;
         end
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         StIdle: begin
            if (start_i) begin
               next_state = ((num_rows_i == '0) || (num_cols_i == '0)) ? StDone : StRun;
            end
         end
         StRun: begin
            if (handshake && last_tile) begin
               next_state = StDone;
            end
         end
         StDone:  next_state = StIdle;
         default: next_state = StIdle;
      endcase
   end

   // Outputs are gated by rst_ni so they read as zero while reset is held,
   // except the write grant, which stays open to the loader at all times.
   always_comb begin
      wr_gnt_o     = wr_req_i && !(rst_ni && (state == StRun) && prev_wr);
      mem_we_o     = wr_gnt_o;
      tile_valid_o = rst_ni && (state == StRun) && !wr_gnt_o;
      busy_o       = rst_ni && ((state == StRun) || (state == StDone));
      done_o       = rst_ni && (state == StDone);
      matrix_col_o = rst_ni ? cols_q  : '0;
      tile_row_o   = rst_ni ? cur_row : '0;
      tile_col_o   = rst_ni ? cur_col : '0;
      if (wr_gnt_o) begin
         mem_addr_o = wr_addr_i;
      end else if (tile_valid_o) begin
         mem_addr_o = rd_addr;
      end else begin
         mem_addr_o = '0;
      end
   end

endmodule

// File: tb/tb_tile_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tile_mem_sequencer
// Self-checking bench for tile_mem_sequencer: a queue-based reference model of
// the tile walk and write arbitration, a table of directed jobs, hand-written
// stall and reset sequences, and randomized jobs.
// -----------------------------------------------------------------------------
module tb_tile_mem_sequencer;

   localparam int AW = 10;
   localparam int DW = 7;
   localparam int TR = 4;
   localparam int TC = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] num_rows;
   logic [DW-1:0] num_cols;
   logic [AW-1:0] base_addr;
   logic          busy;
   logic          done;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic          wr_gnt;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] matrix_col;
   logic          tile_valid;
   logic          tile_ready;
   logic [DW-1:0] tile_row;
   logic [DW-1:0] tile_col;

   always #5 clk = ~clk;

   tile_mem_sequencer #(
      .AddrWidth (AW),
      .TileRows  (TR),
      .TileCols  (TC),
      .DimWidth  (DW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .num_rows_i   (num_rows),
      .num_cols_i   (num_cols),
      .base_addr_i  (base_addr),
      .busy_o       (busy),
      .done_o       (done),
      .wr_req_i     (wr_req),
      .wr_addr_i    (wr_addr),
      .wr_gnt_o     (wr_gnt),
      .mem_addr_o   (mem_addr),
      .mem_we_o     (mem_we),
      .matrix_col_o (matrix_col),
      .tile_valid_o (tile_valid),
      .tile_ready_i (tile_ready),
      .tile_row_o   (tile_row),
      .tile_col_o   (tile_col)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: job mode (0 idle, 1 tiles outstanding, 2 completion
   // cycle), the list of tile origins still to be delivered, and whether the
   // previous cycle granted a write.
   int m_mode = 0;
   bit m_prev_wr = 1'b0;
   int m_rows = 0;
   int m_cols = 0;
   int m_base = 0;
   int q_r[$];
   int q_c[$];

   int cyc = 0;
   int done_cyc = -1;
   int obs_addr[$];

   function automatic void build_tiles(input int rows, input int cols);
      q_r.delete();
      q_c.delete();
      for (int r = 0; r < rows; r += TR)
         for (int c = 0; c < cols; c += TC) begin
            q_r.push_back(r);
            q_c.push_back(c);
         end
   endfunction

   // One clock cycle: compare outputs at the falling edge against the model,
   // record observed handshakes/done, then advance the model at the rising edge.
   task automatic tick();
      bit e_gnt;
      bit e_valid;
      int e_addr;
      @(negedge clk);
      if (!rst_n) begin
         e_gnt = wr_req;
         check("rst_gnt", 32'(wr_gnt), 32'(e_gnt));
         check("rst_we", 32'(mem_we), 32'(e_gnt));
         check("rst_valid", 32'(tile_valid), 0);
         check("rst_busy", 32'(busy), 0);
         check("rst_done", 32'(done), 0);
         check("rst_mcol", 32'(matrix_col), 0);
         check("rst_row", 32'(tile_row), 0);
         check("rst_col", 32'(tile_col), 0);
         check("rst_addr", 32'(mem_addr), e_gnt ? 32'(wr_addr) : 0);
         e_valid = 1'b0;
      end else begin
         e_gnt   = wr_req && !(m_mode == 1 && m_prev_wr);
         e_valid = (m_mode == 1) && !e_gnt;
         check("gnt", 32'(wr_gnt), 32'(e_gnt));
         check("we", 32'(mem_we), 32'(e_gnt));
         check("valid", 32'(tile_valid), 32'(e_valid));
         check("busy", 32'(busy), 32'(m_mode != 0));
         check("done", 32'(done), 32'(m_mode == 2));
         check("mcol", 32'(matrix_col), 32'(m_cols));
         if (e_gnt) begin
            check("wr_addr", 32'(mem_addr), 32'(wr_addr));
         end else if (e_valid) begin
            e_addr = (m_base + q_r[0] * m_cols + q_c[0]) % (1 << AW);
            check("rd_addr", 32'(mem_addr), 32'(e_addr));
            check("tile_row", 32'(tile_row), 32'(q_r[0]));
            check("tile_col", 32'(tile_col), 32'(q_c[0]));
         end
      end
      if (tile_valid === 1'b1 && tile_ready === 1'b1) obs_addr.push_back(int'(mem_addr));
      if (done === 1'b1) done_cyc = cyc;
      @(posedge clk);
      if (!rst_n) begin
         m_mode = 0;
         m_prev_wr = 1'b0;
         m_rows = 0;
         m_cols = 0;
         m_base = 0;
         q_r.delete();
         q_c.delete();
      end else begin
         m_prev_wr = e_gnt;
         case (m_mode)
            0: if (start) begin
               m_rows = int'(num_rows);
               m_cols = int'(num_cols);
               m_base = int'(base_addr);
               build_tiles(m_rows, m_cols);
               m_mode = (q_r.size() == 0) ? 2 : 1;
            end
            1: if (e_valid && tile_ready) begin
               void'(q_r.pop_front());
               void'(q_c.pop_front());
               if (q_r.size() == 0) m_mode = 2;
            end
            default: m_mode = 0;
         endcase
      end
      cyc++;
      #1;
   endtask

   typedef struct {
      int rows;
      int cols;
      int base;
      bit wr_hold;
      int n_tiles;
      int done_lat;
      int addr[4];
   } vec_t;

   vec_t vt[6];

   task automatic run_vec(input int idx, input vec_t v);
      int t0;
      int n;
      obs_addr.delete();
      done_cyc = -1;
      start = 1'b1;
      num_rows = DW'(v.rows);
      num_cols = DW'(v.cols);
      base_addr = AW'(v.base);
      tile_ready = 1'b1;
      wr_req = 1'b0;
      t0 = cyc;
      tick();
      start = 1'b0;
      wr_req = v.wr_hold;
      n = 0;
      while (done_cyc < 0 && n < 50) begin
         wr_addr = AW'($urandom);
         tick();
         n++;
      end
      wr_req = 1'b0;
      check($sformatf("vec%0d_latency", idx), 32'(done_cyc - t0), 32'(v.done_lat));
      check($sformatf("vec%0d_tiles", idx), 32'(obs_addr.size()), 32'(v.n_tiles));
      for (int i = 0; i < 4 && i < v.n_tiles && i < obs_addr.size(); i++)
         check($sformatf("vec%0d_addr%0d", idx, i), 32'(obs_addr[i]), 32'(v.addr[i]));
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // rows, cols, base, write-held, tiles, start-to-done cycles, first addrs
      vt[0] = '{8, 8, 0, 1'b0, 4, 5, '{0, 4, 32, 36}};
      vt[1] = '{6, 5, 0, 1'b0, 4, 5, '{0, 4, 20, 24}};
      vt[2] = '{8, 8, 0, 1'b1, 4, 9, '{0, 4, 32, 36}};
      vt[3] = '{5, 0, 7, 1'b0, 0, 1, '{0, 0, 0, 0}};
      vt[4] = '{1, 1, 100, 1'b0, 1, 2, '{100, 0, 0, 0}};
      vt[5] = '{9, 3, 1020, 1'b0, 3, 4, '{1020, 8, 20, 0}};

      rst_n = 1'b0;
      start = 1'b0;
      num_rows = '0;
      num_cols = '0;
      base_addr = '0;
      wr_req = 1'b1;
      wr_addr = AW'(10'h155);
      tile_ready = 1'b0;
      #1;
      tick();
      tick();
      wr_req = 1'b0;
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

      // Consumer stalls for 5 cycles while tile 2 (origin 4,0) is presented.
      obs_addr.delete();
      done_cyc = -1;
      start = 1'b1;
      num_rows = DW'(8);
      num_cols = DW'(8);
      base_addr = '0;
      tile_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tile_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_addr", 32'(mem_addr), 32);
         check("stall_row", 32'(tile_row), 4);
         check("stall_col", 32'(tile_col), 0);
      end
      tile_ready = 1'b1;
      for (int i = 0; i < 10 && done_cyc < 0; i++) tick();
      check("stall_tiles", 32'(obs_addr.size()), 4);
      if (obs_addr.size() == 4) begin
         check("stall_seq2", 32'(obs_addr[2]), 32);
         check("stall_seq3", 32'(obs_addr[3]), 36);
      end
      tick();

      // Reset while tile 2 of 4 is pending: job aborts without done.
      done_cyc = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("abort_busy", 32'(busy), 0);
      for (int i = 0; i < 6; i++) tick();
      check("abort_no_done", 32'(done_cyc), 32'(-1));
      run_vec(6, vt[1]);

      // Randomized jobs with write traffic, back-pressure, stray starts and
      // occasional mid-job resets.
      for (int j = 0; j < 40; j++) begin
         int n;
         start = 1'b1;
         num_rows = DW'(($urandom % 8 == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12));
         num_cols = DW'(($urandom % 8 == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12));
         base_addr = AW'($urandom);
         wr_req = $urandom_range(0, 1) == 1;
         wr_addr = AW'($urandom);
         tile_ready = 1'b1;
         tick();
         n = 0;
         while (m_mode != 0 && n < 2000) begin
            start = ($urandom % 10) == 0;
            num_rows = DW'($urandom);
            num_cols = DW'($urandom);
            base_addr = AW'($urandom);
            wr_req = ($urandom % 3) == 0;
            wr_addr = AW'($urandom);
            tile_ready = ($urandom % 4) != 0;
            rst_n = ($urandom % 80) != 0;
            tick();
            n++;
         end
         check("rand_job_bound", 32'(n < 2000), 1);
         start = 1'b0;
         rst_n = 1'b1;
         wr_req = 1'b0;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
